bus_transfer_sequencer: RTL and testbench
=========================================

Name: bus_transfer_sequencer

Overview:
- Control-side counterpart of the bus-attached registers on the shared 8-bit tri-state bus.
- Registers such as the accumulator react to an active-high output enable (drive bus) and an active-low load (capture bus on posedge clk). This block generates those strobes.
- Accepts one register-to-register transfer request at a time (source ID, destination ID) and sequences enable and load so that exactly one agent drives the bus and the destination captures a settled value.

Parameters:
- N_AGENTS, 4, number of bus-attached registers; index i maps to out_en[i] and load_n[i].
- ID_W, 2, width of source/destination IDs; must satisfy 2^ID_W >= N_AGENTS.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  transfer request present.
- req_ready  output  1  sequencer can accept a request (IDLE only).
- req_src  input  ID_W  index of agent to drive the bus.
- req_dst  input  ID_W  index of agent to load from the bus.
- out_en  output  N_AGENTS  per-agent bus output enable, active-high, at most one bit set.
- load_n  output  N_AGENTS  per-agent load strobe, active-low.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse; transfer completed.
- err  output  1  one-cycle pulse; request rejected.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- All outputs are driven from registers; no combinational path from req_* to out_en/load_n.
- Reset (sampled at posedge with rst=1):
  - state IDLE, out_en=0, load_n=all 1s, busy=0, done=0, err=0, req_ready=1 from the following cycle.
  - Reset mid-transfer aborts immediately, with no load strobe after reset is sampled.
- States: IDLE, DRIVE, LOAD, RELEASE, ERROR.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at posedge (acceptance edge), latch src/dst.
  - If src==dst, src>=N_AGENTS, or dst>=N_AGENTS, go to ERROR; otherwise go to DRIVE.
  - req_ready=0 in all other states; requests there are ignored and not queued.
- DRIVE (cycle A+1):
  - out_en[src]=1, load_n all 1s.
  - Bus settle cycle: load is never asserted in the first cycle a source drives.
- LOAD (cycle A+2):
  - out_en[src]=1, load_n[dst]=0, all other load_n bits 1.
  - Destination captures the bus at the posedge closing this cycle.
- RELEASE (cycle A+3):
  - out_en=0, load_n all 1s, done=1.
  - Next state IDLE; req_ready=1 at A+4.
- ERROR (cycle A+1):
  - err=1, out_en=0, load_n all 1s, done=0.
  - Next state IDLE; req_ready=1 at A+2.
- Throughput:
  - Valid transfer: 4 cycles from acceptance to next acceptance.
  - Error: 2 cycles.
- Invariants, checked every cycle:
  - popcount(out_en) <= 1.
  - popcount(~load_n) <= 1.
  - Any load_n bit low implies out_en[src] high and state LOAD.
  - done and err never high together.
  - busy == !req_ready outside reset.
- Latched src/dst are stable from acceptance through RELEASE, whatever req_* does.
- When N_AGENTS < 2^ID_W, out-of-range IDs go to ERROR. Outputs for indices >= N_AGENTS do not exist.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release.
  -> out_en=4'b0000, load_n=4'b1111, busy=0, done=0, err=0, req_ready=1.
- Valid transfer: req src=0, dst=2, valid one cycle.
  -> A+1: out_en=0001, load_n=1111.
  -> A+2: out_en=0001, load_n=1011.
  -> A+3: out_en=0000, done=1.
  -> A+4: req_ready=1.
  -> Bench model: agent2 register holds agent0's value 8'hA5 after A+2 edge.
- Error: req src=1, dst=1.
  -> A+1: err=1, out_en=0000, load_n=1111.
  -> A+2: req_ready=1.
  -> No agent register changes.
- Back-to-back: req_valid held high with src=3, dst=0, then src=0, dst=1.
  -> Second acceptance exactly at A+4.
  -> Requests presented during busy are ignored.
  -> Invariants hold throughout.
- Reset mid-transfer: assert rst in the LOAD cycle (load_n=1110 pending for src=2, dst=0).
  -> Following cycle: out_en=0000, load_n=1111, done=0.
  -> Agent0 loads only if the LOAD edge preceded rst sampling.
  -> Sequencer in IDLE.
- Out-of-range: N_AGENTS=3, ID_W=2, req src=3, dst=0.
  -> err=1 at A+1; no out_en bit ever set.

Source files
------------

// File: rtl/bus_transfer_sequencer.sv
// Strobe sequencer for the shared 8-bit bus: runs one register-to-register
// transfer at a time as a settle (drive-only) cycle, then a load cycle, then a release.
module bus_transfer_sequencer #(
  parameter int N_AGENTS = 4,
  parameter int ID_W     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ID_W-1:0]     req_src,
  input  logic [ID_W-1:0]     req_dst,
  output logic [N_AGENTS-1:0] out_en,
  output logic [N_AGENTS-1:0] load_n,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int N_IDS = 2 ** ID_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_LOAD,
    S_RELEASE,
    S_ERROR
  } state_t;

  state_t                state_q;
  logic [ID_W-1:0]       src_q;
  logic [ID_W-1:0]       dst_q;
  logic [N_AGENTS-1:0]   out_en_q;
  logic [N_AGENTS-1:0]   load_n_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  // Constant table of which IDs map to an existing agent.
  logic [N_IDS-1:0]      id_ok;
  logic                  req_bad;

  for (genvar gi = 0; gi < N_IDS; gi++) begin : g_id_ok
    assign id_ok[gi] = (gi < N_AGENTS);
  end

  assign req_bad = (req_src == req_dst) || !id_ok[req_src] || !id_ok[req_dst];

  function automatic logic [N_AGENTS-1:0] decode(input logic [ID_W-1:0] id);
    logic [N_AGENTS-1:0] v;
    for (int i = 0; i < N_AGENTS; i++) begin
      v[i] = (id == ID_W'(i));
    end
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      out_en_q <= '0;
      load_n_q <= '1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            src_q   <= req_src;
            dst_q   <= req_dst;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (req_bad) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end else begin
              state_q  <= S_DRIVE;
              out_en_q <= decode(req_src);
            end
          end
        end
        S_DRIVE: begin
          // Source has driven for one full cycle; the bus is settled, so load now.
          state_q  <= S_LOAD;
          out_en_q <= decode(src_q);
          load_n_q <= ~decode(dst_q);
        end
        S_LOAD: begin
          state_q  <= S_RELEASE;
          out_en_q <= '0;
          load_n_q <= '1;
          done_q   <= 1'b1;
        end
        S_RELEASE, S_ERROR: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          out_en_q <= '0;
          load_n_q <= '1;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign out_en    = out_en_q;
  assign load_n    = load_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Scoreboard bench: stimulus queues expected strobe snapshots, a negedge monitor
// pops one per active output cycle; a 3-agent instance covers out-of-range IDs.
module tb_bus_transfer_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_src, req_dst;
  logic       req_ready, busy, done, err;
  logic [3:0] out_en, load_n;

  logic       v3;
  logic [1:0] s3, d3;
  logic       ready3, busy3, done3, err3;
  logic [2:0] oe3, ln3;

  int vectors = 0;
  int miscompares = 0;

  // Expected snapshot: {out_en, load_n, done, err}
  logic [9:0] exp_q[$];

  logic [7:0] agent[4];
  logic [7:0] bus;
  logic       seeded = 1'b0;

  bus_transfer_sequencer #(.N_AGENTS(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .out_en(out_en), .load_n(load_n),
    .busy(busy), .done(done), .err(err)
  );

  bus_transfer_sequencer #(.N_AGENTS(3), .ID_W(2)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(ready3),
    .req_src(s3), .req_dst(d3), .out_en(oe3), .load_n(ln3),
    .busy(busy3), .done(done3), .err(err3)
  );

  always #5 clk = ~clk;

  // Bus and register model of the attached agents.
  always_comb begin
    case (out_en)
      4'b0001: bus = agent[0];
      4'b0010: bus = agent[1];
      4'b0100: bus = agent[2];
      4'b1000: bus = agent[3];
      4'b0000: bus = 8'h00;
      default: bus = 8'hxx;
    endcase
  end

  always @(posedge clk) begin
    if (!seeded) begin
      agent[0] <= 8'hA5;
      agent[1] <= 8'h3C;
      agent[2] <= 8'h00;
      agent[3] <= 8'h77;
      seeded   <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!load_n[i]) agent[i] <= bus;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on every active output cycle.
  always @(negedge clk) begin
    if ($time > 6) begin
      if (!rst) begin
        chk("inv_oe_onehot", 16'($countones(out_en) <= 1), 16'd1);
        chk("inv_load_onehot", 16'($countones(~load_n) <= 1), 16'd1);
        chk("inv_done_err", 16'(done && err), 16'd0);
        chk("inv_busy_ready", 16'(busy), 16'(!req_ready));
        if (load_n != 4'b1111)
          chk("inv_load_needs_drive", 16'(out_en != 4'b0000), 16'd1);
        chk("n3_out_en_never", 16'(oe3), 16'd0);
        chk("n3_load_idle", 16'(ln3), 16'h7);
        chk("n3_no_done", 16'(done3), 16'd0);
        chk("n3_busy_ready", 16'(busy3), 16'(!ready3));
      end
      if (out_en != 4'b0000 || load_n != 4'b1111 || done || err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 16'({out_en, load_n, done, err}), 16'h3C0);
        end else begin
          chk("scoreboard", 16'({out_en, load_n, done, err}), 16'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_src = '0; req_dst = '0;
    v3 = 1'b0; s3 = '0; d3 = '0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_en", 16'(out_en), 16'h0);
    chk("rst_load_n", 16'(load_n), 16'hF);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_ready", 16'(req_ready), 16'd1);
    tick();

    // Valid transfer 0 -> 2
    exp_q.push_back({4'b0001, 4'b1111, 1'b0, 1'b0});
    exp_q.push_back({4'b0001, 4'b1011, 1'b0, 1'b0});
    exp_q.push_back({4'b0000, 4'b1111, 1'b1, 1'b0});
    req_valid = 1'b1; req_src = 2'd0; req_dst = 2'd2;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("xfer_ready_a1", 16'(req_ready), 16'd0);
    chk("xfer_busy_a1", 16'(busy), 16'd1);
    tick(); tick();
    @(negedge clk);
    chk("xfer_ready_a3", 16'(req_ready), 16'd0);
    chk("xfer_agent2", 16'(agent[2]), 16'hA5);
    tick();
    @(negedge clk);
    chk("xfer_ready_a4", 16'(req_ready), 16'd1);

    // Rejected request src == dst
    exp_q.push_back({4'b0000, 4'b1111, 1'b0, 1'b1});
    req_valid = 1'b1; req_src = 2'd1; req_dst = 2'd1;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("err_ready_a1", 16'(req_ready), 16'd0);
    tick();
    @(negedge clk);
    chk("err_ready_a2", 16'(req_ready), 16'd1);
    chk("err_agent0", 16'(agent[0]), 16'hA5);
    chk("err_agent1", 16'(agent[1]), 16'h3C);
    chk("err_agent3", 16'(agent[3]), 16'h77);

    // Back-to-back with valid held: 3 -> 0 then 0 -> 1
    exp_q.push_back({4'b1000, 4'b1111, 1'b0, 1'b0});
    exp_q.push_back({4'b1000, 4'b1110, 1'b0, 1'b0});
    exp_q.push_back({4'b0000, 4'b1111, 1'b1, 1'b0});
    exp_q.push_back({4'b0001, 4'b1111, 1'b0, 1'b0});
    exp_q.push_back({4'b0001, 4'b1101, 1'b0, 1'b0});
    exp_q.push_back({4'b0000, 4'b1111, 1'b1, 1'b0});
    req_valid = 1'b1; req_src = 2'd3; req_dst = 2'd0;
    tick();
    req_src = 2'd0; req_dst = 2'd1;
    tick();
    @(negedge clk);
    chk("b2b_ready_busy", 16'(req_ready), 16'd0);
    tick(); tick();
    @(negedge clk);
    chk("b2b_ready_a4", 16'(req_ready), 16'd1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_drive", 16'(out_en), 16'b0001);
    tick(); tick(); tick();
    @(negedge clk);
    chk("b2b_agent0", 16'(agent[0]), 16'h77);
    chk("b2b_agent1", 16'(agent[1]), 16'h77);

    // Reset asserted during the LOAD cycle of 2 -> 0
    exp_q.push_back({4'b0100, 4'b1111, 1'b0, 1'b0});
    exp_q.push_back({4'b0100, 4'b1110, 1'b0, 1'b0});
    req_valid = 1'b1; req_src = 2'd2; req_dst = 2'd0;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_en", 16'(out_en), 16'h0);
    chk("mrst_load_n", 16'(load_n), 16'hF);
    chk("mrst_done", 16'(done), 16'd0);
    chk("mrst_ready", 16'(req_ready), 16'd1);
    chk("mrst_busy", 16'(busy), 16'd0);
    tick(); tick();

    // Out-of-range IDs on the 3-agent instance
    v3 = 1'b1; s3 = 2'd3; d3 = 2'd0;
    tick();
    v3 = 1'b0;
    @(negedge clk);
    chk("n3_src_err", 16'(err3), 16'd1);
    chk("n3_src_ready", 16'(ready3), 16'd0);
    tick();
    @(negedge clk);
    chk("n3_err_clear", 16'(err3), 16'd0);
    chk("n3_ready_a2", 16'(ready3), 16'd1);
    v3 = 1'b1; s3 = 2'd0; d3 = 2'd3;
    tick();
    v3 = 1'b0;
    @(negedge clk);
    chk("n3_dst_err", 16'(err3), 16'd1);
    tick(); tick();

    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
